sr_flag_arbiter: RTL

- Bank of N_FLAGS SR-type flag flip-flops shared by N_REQ requesters.
- Each requester issues an S/R command against one flag index. A round-robin arbiter serialises the commands, one per clock.
- Sits between control FSMs (requesters) and status logic that reads the flags. Replaces ad-hoc per-client SR flip-flops driven from several places.

---
 rtl/sr_flag_pkg.sv | 15 +
 rtl/rr_arbiter.sv | 27 ++
 rtl/sr_flag_arbiter.sv | 109 ++++++++++
 3 files changed

// File: rtl/sr_flag_pkg.sv
// Shared definitions for the SR flag arbiter: command encodings and default sizes.
package sr_flag_pkg;

  typedef enum logic [1:0] {
    SR_HOLD = 2'b00,
    SR_CLR  = 2'b01,
    SR_SET  = 2'b10,
    SR_ILL  = 2'b11
  } sr_cmd_e;

  localparam int N_REQ_DEF   = 4;
  localparam int N_FLAGS_DEF = 8;
  localparam int CNT_W_DEF   = 8;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first set bit of i_req searching upward from i_ptr+1.
module rr_arbiter #(
  parameter  int N  = 4,
  localparam int PW = $clog2(N)
) (
  input  logic [N-1:0]  i_req,
  input  logic [PW-1:0] i_ptr,
  output logic [N-1:0]  o_gnt
);

  logic [PW-1:0] w_pos;
  logic          w_found;

  always_comb begin
    o_gnt   = '0;
    w_found = 1'b0;
    w_pos   = '0;
    for (int i = 1; i <= N; i++) begin
      w_pos = PW'((int'(i_ptr) + i) % N);
      if (!w_found && i_req[w_pos]) begin
        o_gnt[w_pos] = 1'b1;
        w_found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/sr_flag_arbiter.sv
// Bank of SR flags shared by several requesters; one command is executed per clock,
// chosen round-robin, with error reporting and a saturating contention counter.
module sr_flag_arbiter
  import sr_flag_pkg::*;
#(
  parameter  int N_REQ   = N_REQ_DEF,
  parameter  int N_FLAGS = N_FLAGS_DEF,
  parameter  int CNT_W   = CNT_W_DEF,
  localparam int IDX_W   = $clog2(N_FLAGS),
  localparam int ID_W    = $clog2(N_REQ)
) (
  input  logic                   clk,
  input  logic                   CLR,
  input  logic                   clr_all,
  input  logic [N_REQ-1:0]       req,
  input  logic [N_REQ-1:0]       s_in,
  input  logic [N_REQ-1:0]       r_in,
  input  logic [N_REQ*IDX_W-1:0] idx_in,
  output logic [N_REQ-1:0]       gnt,
  output logic [N_FLAGS-1:0]     Q,
  output logic [N_FLAGS-1:0]     Q_not,
  output logic                   err,
  output logic [ID_W-1:0]        err_id,
  output logic [CNT_W-1:0]       cont_cnt
);

  logic [N_REQ-1:0]   r_gnt;
  logic [ID_W-1:0]    r_ptr;
  logic [N_FLAGS-1:0] r_q;
  logic [N_FLAGS-1:0] r_q_not;
  logic               r_err;
  logic [ID_W-1:0]    r_err_id;
  logic [CNT_W-1:0]   r_cnt;

  logic [N_REQ-1:0]   w_elig;
  logic [N_REQ-1:0]   w_win;
  logic               w_any;
  logic [ID_W-1:0]    w_win_id;
  logic [IDX_W-1:0]   w_f;
  sr_cmd_e            w_cmd;
  logic               w_illegal;
  logic               w_contend;
  logic [N_FLAGS-1:0] w_q_next;

  // A requester just granted is masked so a held req cannot win twice in a row.
  assign w_elig = req & ~r_gnt;

  rr_arbiter #(.N(N_REQ)) u_rr (
    .i_req (w_elig),
    .i_ptr (r_ptr),
    .o_gnt (w_win)
  );

  assign w_any = |w_win;

  always_comb begin
    w_win_id = '0;
    for (int k = 0; k < N_REQ; k++) begin
      if (w_win[k]) w_win_id = ID_W'(k);
    end
  end

  assign w_f       = idx_in[int'(w_win_id)*IDX_W +: IDX_W];
  assign w_cmd     = sr_cmd_e'({s_in[w_win_id], r_in[w_win_id]});
  assign w_illegal = w_any && !clr_all && ((w_cmd == SR_ILL) || (int'(w_f) >= N_FLAGS));
  assign w_contend = |(w_elig & (w_elig - N_REQ'(1)));

  always_comb begin
    w_q_next = r_q;
    if (clr_all) begin
      w_q_next = '0;
    end else if (w_any && !w_illegal) begin
      case (w_cmd)
        SR_CLR:  w_q_next[w_f] = 1'b0;
        SR_SET:  w_q_next[w_f] = 1'b1;
        default: w_q_next = r_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge CLR) begin
    if (!CLR) begin
      r_gnt    <= '0;
      r_ptr    <= ID_W'(N_REQ - 1);
      r_q      <= '0;
      r_q_not  <= '1;
      r_err    <= 1'b0;
      r_err_id <= '0;
      r_cnt    <= '0;
    end else begin
      r_gnt   <= w_win;
      r_q     <= w_q_next;
      // Complement taken from the next state so it never lags Q.
      r_q_not <= ~w_q_next;
      r_err   <= w_illegal;
      if (w_any) r_ptr <= w_win_id;
      if (w_illegal) r_err_id <= w_win_id;
      if (w_contend && (r_cnt != {CNT_W{1'b1}})) r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign gnt      = r_gnt;
  assign Q        = r_q;
  assign Q_not    = r_q_not;
  assign err      = r_err;
  assign err_id   = r_err_id;
  assign cont_cnt = r_cnt;

endmodule
